// File: rtl/r5p_degu_tcb_arb.sv
// Two-manager TCB arbiter: merges the IFU and LSU busses onto one subordinate
// and steers each response back to its requester after the fixed delay DLY.
module r5p_degu_tcb_arb #(
  parameter int DLY = 1,
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int BW  = DW/8,
  parameter bit RR  = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  // IFU manager
  input  logic          ifu_vld,
  input  logic          ifu_wen,
  input  logic [AW-1:0] ifu_adr,
  input  logic [BW-1:0] ifu_ben,
  input  logic [DW-1:0] ifu_wdt,
  output logic          ifu_rdy,
  output logic [DW-1:0] ifu_rdt,
  output logic          ifu_err,
  // LSU manager
  input  logic          lsu_vld,
  input  logic          lsu_wen,
  input  logic [AW-1:0] lsu_adr,
  input  logic [BW-1:0] lsu_ben,
  input  logic [DW-1:0] lsu_wdt,
  output logic          lsu_rdy,
  output logic [DW-1:0] lsu_rdt,
  output logic          lsu_err,
  // shared subordinate
  output logic          sub_vld,
  output logic          sub_wen,
  output logic [AW-1:0] sub_adr,
  output logic [BW-1:0] sub_ben,
  output logic [DW-1:0] sub_wdt,
  input  logic          sub_rdy,
  input  logic [DW-1:0] sub_rdt,
  input  logic          sub_err,
  output logic          sub_gnt
);

  // Handshake: a transfer happens on any port in a cycle where vld & rdy are
  // both high; a manager holds vld and its fields stable until it sees rdy.

  logic lock_q, lock_d;
  logic lgnt_q, lgnt_d;
  logic last_q, last_d;
  logic gnt;
  logic xfer;
  logic rsp_v;
  logic rsp_id;
  logic ifu_sel;
  logic lsu_sel;

  // Grant: a stalled request keeps its owner; ties go round-robin or to the LSU.
  always_comb begin
    gnt = last_q;
    if (lock_q) begin
      gnt = lgnt_q;
    end else if (ifu_vld && !lsu_vld) begin
      gnt = 1'b0;
    end else if (!ifu_vld && lsu_vld) begin
      gnt = 1'b1;
    end else if (ifu_vld && lsu_vld) begin
      gnt = RR ? ~last_q : 1'b1;
    end
  end

  // Request path; held quiet while reset is asserted.
  always_comb begin
    sub_vld = ~rst & (gnt ? lsu_vld : ifu_vld);
    sub_wen = gnt ? lsu_wen : ifu_wen;
    sub_adr = gnt ? lsu_adr : ifu_adr;
    sub_ben = gnt ? lsu_ben : ifu_ben;
    sub_wdt = gnt ? lsu_wdt : ifu_wdt;
    ifu_rdy = ~rst & ~gnt & sub_rdy;
    lsu_rdy = ~rst &  gnt & sub_rdy;
    sub_gnt = gnt;
    xfer    = sub_vld & sub_rdy;
  end

  always_comb begin
    lock_d = lock_q;
    lgnt_d = lgnt_q;
    last_d = last_q;
    if (xfer) begin
      lock_d = 1'b0;
      last_d = gnt;
    end else if (sub_vld) begin
      lock_d = 1'b1;
      lgnt_d = gnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q <= 1'b0;
      lgnt_q <= 1'b0;
      last_q <= 1'b1;
    end else begin
      lock_q <= lock_d;
      lgnt_q <= lgnt_d;
      last_q <= last_d;
    end
  end

  generate
    if (DLY == 0) begin : g_rsp_comb
      always_comb begin
        rsp_v  = xfer;
        rsp_id = gnt;
      end
    end else begin : g_rsp_pipe
      logic [DLY-1:0] v_q, v_d;
      logic [DLY-1:0] id_q, id_d;

      // Each stage carries {valid, owner} of one accepted request.
      always_comb begin
        v_d     = v_q;
        id_d    = id_q;
        v_d[0]  = xfer;
        id_d[0] = gnt;
        for (int i = 1; i < DLY; i++) begin
          v_d[i]  = v_q[i-1];
          id_d[i] = id_q[i-1];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_q  <= '0;
          id_q <= '0;
        end else begin
          v_q  <= v_d;
          id_q <= id_d;
        end
      end

      always_comb begin
        rsp_v  = v_q[DLY-1];
        rsp_id = id_q[DLY-1];
      end
    end
  endgenerate

  always_comb begin
    ifu_sel = ~rst & rsp_v & ~rsp_id;
    lsu_sel = ~rst & rsp_v &  rsp_id;
    ifu_rdt = ifu_sel ? sub_rdt : '0;
    ifu_err = ifu_sel & sub_err;
    lsu_rdt = lsu_sel ? sub_rdt : '0;
    lsu_err = lsu_sel & sub_err;
  end

endmodule

// File: tb/tb_r5p_degu_tcb_arb.sv
// Bench for r5p_degu_tcb_arb: instance 0 is DLY=1 round-robin, instance 1 is
// DLY=2 fixed priority; directed vectors with an in-order expected queue.
module tb_r5p_degu_tcb_arb;

  localparam int DLY_A = 1;
  localparam int DLY_B = 2;

  typedef struct {
    logic        wen;
    logic [31:0] adr;
    logic [3:0]  ben;
    logic [31:0] wdt;
  } req_t;

  typedef struct {
    logic        own;
    logic        wen;
    logic [31:0] adr;
    logic [3:0]  ben;
    logic [31:0] wdt;
    logic [31:0] rdt;
    logic        err;
  } exp_t;

  typedef struct {
    int unsigned due;
    logic        own;
    logic [31:0] rdt;
    logic        err;
  } rsp_t;

  // clock/reset
  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]       ifu_vld, ifu_wen, lsu_vld, lsu_wen, sub_rdy, sub_err;
  logic [1:0][31:0] ifu_adr, ifu_wdt, lsu_adr, lsu_wdt, sub_rdt;
  logic [1:0][3:0]  ifu_ben, lsu_ben;
  wire  [1:0]       ifu_rdy, ifu_err, lsu_rdy, lsu_err, sub_vld, sub_wen, sub_gnt;
  wire  [1:0][31:0] ifu_rdt, lsu_rdt, sub_adr, sub_wdt;
  wire  [1:0][3:0]  sub_ben;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    r5p_degu_tcb_arb #(
      .DLY (g == 0 ? DLY_A : DLY_B),
      .AW  (32),
      .DW  (32),
      .BW  (4),
      .RR  (g == 0 ? 1'b1 : 1'b0)
    ) dut (
      .clk     (clk),
      .rst     (rst),
      .ifu_vld (ifu_vld[g]),
      .ifu_wen (ifu_wen[g]),
      .ifu_adr (ifu_adr[g]),
      .ifu_ben (ifu_ben[g]),
      .ifu_wdt (ifu_wdt[g]),
      .ifu_rdy (ifu_rdy[g]),
      .ifu_rdt (ifu_rdt[g]),
      .ifu_err (ifu_err[g]),
      .lsu_vld (lsu_vld[g]),
      .lsu_wen (lsu_wen[g]),
      .lsu_adr (lsu_adr[g]),
      .lsu_ben (lsu_ben[g]),
      .lsu_wdt (lsu_wdt[g]),
      .lsu_rdy (lsu_rdy[g]),
      .lsu_rdt (lsu_rdt[g]),
      .lsu_err (lsu_err[g]),
      .sub_vld (sub_vld[g]),
      .sub_wen (sub_wen[g]),
      .sub_adr (sub_adr[g]),
      .sub_ben (sub_ben[g]),
      .sub_wdt (sub_wdt[g]),
      .sub_rdy (sub_rdy[g]),
      .sub_rdt (sub_rdt[g]),
      .sub_err (sub_err[g]),
      .sub_gnt (sub_gnt[g])
    );
  end

  // scoreboard state
  req_t req_q[4][$];
  exp_t exp_q[2][$];
  rsp_t rsp_q[2][$];
  rsp_t cur[2];
  logic cur_v[2];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input int i, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at cycle %0d: got %h expected %h", nm, i, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // driver tasks
  task automatic req(input int i, input logic own, input logic wen, input logic [31:0] adr,
                     input logic [3:0] ben, input logic [31:0] wdt);
    req_t r;
    r.wen = wen; r.adr = adr; r.ben = ben; r.wdt = wdt;
    req_q[i*2 + int'(own)].push_back(r);
  endtask

  task automatic expect_xfer(input int i, input logic own, input logic wen, input logic [31:0] adr,
                             input logic [3:0] ben, input logic [31:0] wdt,
                             input logic [31:0] rdt, input logic err);
    exp_t e;
    e.own = own; e.wen = wen; e.adr = adr; e.ben = ben; e.wdt = wdt; e.rdt = rdt; e.err = err;
    exp_q[i].push_back(e);
  endtask

  task automatic set_mgr(input int i, input int own, input logic vld, input req_t r);
    if (own == 1) begin
      lsu_vld[i] = vld; lsu_wen[i] = r.wen; lsu_adr[i] = r.adr; lsu_ben[i] = r.ben; lsu_wdt[i] = r.wdt;
    end else begin
      ifu_vld[i] = vld; ifu_wen[i] = r.wen; ifu_adr[i] = r.adr; ifu_ben[i] = r.ben; ifu_wdt[i] = r.wdt;
    end
  endtask

  task automatic drive(input int i, input int own);
    logic busy;
    logic fired;
    req_t r;
    int   k;
    busy = 1'b0; fired = 1'b0; k = i*2 + own;
    r.wen = 1'b0; r.adr = '0; r.ben = '0; r.wdt = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        busy = 1'b0;
        set_mgr(i, own, 1'b0, r);
      end else begin
        if (busy && fired) busy = 1'b0;
        if (!busy && req_q[k].size() > 0) begin
          r = req_q[k].pop_front();
          busy = 1'b1;
          set_mgr(i, own, 1'b1, r);
        end else if (!busy) begin
          set_mgr(i, own, 1'b0, r);
        end
      end
      @(negedge clk);
      fired = (own == 1) ? (lsu_vld[i] & lsu_rdy[i]) : (ifu_vld[i] & ifu_rdy[i]);
    end
  endtask

  // subordinate: presents the response due this cycle, otherwise junk
  task automatic sub_model(input int i);
    forever begin
      @(posedge clk);
      #1;
      cur_v[i] = 1'b0;
      if (rsp_q[i].size() > 0 && rsp_q[i][0].due == cyc) begin
        cur[i]     = rsp_q[i].pop_front();
        cur_v[i]   = 1'b1;
        sub_rdt[i] = cur[i].rdt;
        sub_err[i] = cur[i].err;
      end else begin
        sub_rdt[i] = 32'hBAD0_0000 | cyc;
        sub_err[i] = cyc[0];
      end
    end
  endtask

  task automatic monitor(input int i);
    exp_t        e;
    rsp_t        r;
    logic [31:0] e_ifu, e_lsu;
    logic        e_ifu_err, e_lsu_err;
    forever begin
      @(negedge clk);
      e_ifu     = (cur_v[i] && !cur[i].own) ? cur[i].rdt : 32'h0;
      e_lsu     = (cur_v[i] &&  cur[i].own) ? cur[i].rdt : 32'h0;
      e_ifu_err = cur_v[i] && !cur[i].own && cur[i].err;
      e_lsu_err = cur_v[i] &&  cur[i].own && cur[i].err;
      chk(i, "ifu_rdt", ifu_rdt[i], e_ifu);
      chk(i, "ifu_err", 32'(ifu_err[i]), 32'(e_ifu_err));
      chk(i, "lsu_rdt", lsu_rdt[i], e_lsu);
      chk(i, "lsu_err", 32'(lsu_err[i]), 32'(e_lsu_err));
      if (!rst && sub_vld[i]) begin
        if (exp_q[i].size() == 0) begin
          chk(i, "unexpected_sub_vld", 32'(sub_vld[i]), 32'h0);
        end else begin
          e = exp_q[i][0];
          chk(i, "sub_gnt", 32'(sub_gnt[i]), 32'(e.own));
          chk(i, "sub_adr", sub_adr[i], e.adr);
          chk(i, "sub_wen", 32'(sub_wen[i]), 32'(e.wen));
          chk(i, "sub_ben", 32'(sub_ben[i]), 32'(e.ben));
          chk(i, "sub_wdt", sub_wdt[i], e.wdt);
          chk(i, "rdy_both", 32'(ifu_rdy[i] & lsu_rdy[i]), 32'h0);
          if (sub_rdy[i]) begin
            chk(i, "owner_rdy", 32'(e.own ? lsu_rdy[i] : ifu_rdy[i]), 32'h1);
            void'(exp_q[i].pop_front());
            r.due = cyc + ((i == 0) ? DLY_A : DLY_B);
            r.own = e.own; r.rdt = e.rdt; r.err = e.err;
            rsp_q[i].push_back(r);
          end
        end
      end
    end
  endtask

  function automatic bit is_idle(input int i);
    return req_q[i*2].size() == 0 && req_q[i*2+1].size() == 0 && exp_q[i].size() == 0 &&
           rsp_q[i].size() == 0 && !cur_v[i] && !ifu_vld[i] && !lsu_vld[i];
  endfunction

  task automatic wait_idle(input int i);
    for (int k = 0; k < 200; k++) begin
      if (is_idle(i)) break;
      tick();
    end
    chk(i, "drain_left", 32'(exp_q[i].size() + rsp_q[i].size()), 32'h0);
  endtask

  task automatic chk_quiet(input int i);
    chk(i, "rst_sub_vld", 32'(sub_vld[i]), 32'h0);
    chk(i, "rst_ifu_rdy", 32'(ifu_rdy[i]), 32'h0);
    chk(i, "rst_lsu_rdy", 32'(lsu_rdy[i]), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    ifu_vld = '0; ifu_wen = '0; ifu_adr = '0; ifu_ben = '0; ifu_wdt = '0;
    lsu_vld = '0; lsu_wen = '0; lsu_adr = '0; lsu_ben = '0; lsu_wdt = '0;
    sub_rdy = 2'b11; sub_rdt = '0; sub_err = '0;
    cur_v[0] = 1'b0; cur_v[1] = 1'b0;
    fork
      drive(0, 0); drive(0, 1); drive(1, 0); drive(1, 1);
      sub_model(0); sub_model(1);
      monitor(0); monitor(1);
    join_none

    repeat (2) @(negedge clk);
    chk_quiet(0);
    chk_quiet(1);
    tick();
    rst = 1'b0;

    // RR contention: IFU wins the first tie, then strict alternation
    tick();
    for (int n = 0; n < 4; n++) begin
      req(0, 1'b0, 1'b0, 32'h0000_1000 + 32'(4*n), 4'hF, 32'h0);
      req(0, 1'b1, 1'b0, 32'h0000_2000 + 32'(4*n), 4'hF, 32'h0);
      expect_xfer(0, 1'b0, 1'b0, 32'h0000_1000 + 32'(4*n), 4'hF, 32'h0, 32'hAAAA_0000 + 32'(n), 1'b0);
      expect_xfer(0, 1'b1, 1'b0, 32'h0000_2000 + 32'(4*n), 4'hF, 32'h0, 32'h5555_0000 + 32'(n), 1'b0);
    end
    wait_idle(0);

    // IFU solo, back-to-back reads
    for (int n = 0; n < 4; n++) begin
      req(0, 1'b0, 1'b0, 32'(4*n), 4'hF, 32'h0);
      expect_xfer(0, 1'b0, 1'b0, 32'(4*n), 4'hF, 32'h0, 32'hC0DE_0000 + 32'(n), 1'b0);
    end
    wait_idle(0);

    // stalled IFU request keeps the grant while the LSU waits
    tick();
    sub_rdy[0] = 1'b0;
    req(0, 1'b0, 1'b0, 32'h0000_0100, 4'hF, 32'h0);
    expect_xfer(0, 1'b0, 1'b0, 32'h0000_0100, 4'hF, 32'h0, 32'h0100_0001, 1'b0);
    expect_xfer(0, 1'b1, 1'b0, 32'h0000_0104, 4'hF, 32'h0, 32'h0104_0002, 1'b0);
    tick();
    req(0, 1'b1, 1'b0, 32'h0000_0104, 4'hF, 32'h0);
    repeat (3) tick();
    sub_rdy[0] = 1'b1;
    wait_idle(0);

    // LSU store with error response
    req(0, 1'b1, 1'b1, 32'h0000_0200, 4'b0011, 32'hDEAD_BEEF);
    expect_xfer(0, 1'b1, 1'b1, 32'h0000_0200, 4'b0011, 32'hDEAD_BEEF, 32'h0, 1'b1);
    wait_idle(0);

    // fixed priority: LSU served three times before the IFU
    tick();
    req(1, 1'b0, 1'b0, 32'h0000_0300, 4'hF, 32'h0);
    for (int n = 0; n < 3; n++) begin
      req(1, 1'b1, 1'b0, 32'h0000_0400 + 32'(4*n), 4'hF, 32'h0);
      expect_xfer(1, 1'b1, 1'b0, 32'h0000_0400 + 32'(4*n), 4'hF, 32'h0, 32'h4444_0000 + 32'(n), 1'b0);
    end
    expect_xfer(1, 1'b0, 1'b0, 32'h0000_0300, 4'hF, 32'h0, 32'h3333_0000, 1'b0);
    wait_idle(1);

    // reset with two responses in flight (DLY=2): nothing may surface
    tick();
    req(1, 1'b0, 1'b0, 32'h0000_0500, 4'hF, 32'h0);
    req(1, 1'b0, 1'b0, 32'h0000_0504, 4'hF, 32'h0);
    expect_xfer(1, 1'b0, 1'b0, 32'h0000_0500, 4'hF, 32'h0, 32'h5000_0000, 1'b0);
    expect_xfer(1, 1'b0, 1'b0, 32'h0000_0504, 4'hF, 32'h0, 32'h5000_0001, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    exp_q[1].delete();
    rsp_q[1].delete();
    cur_v[1] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk_quiet(1);
    end
    tick();
    rst = 1'b0;
    repeat (4) tick();
    wait_idle(0);
    wait_idle(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/r5p_degu_tcb_arb.md
Name: r5p_degu_tcb_arb

Overview:
- Two-manager TCB arbiter that merges the R5P-degu IFU and LSU busses onto one shared TCB subordinate, such as a unified SRAM or a system bus.
- Selects one request per cycle, forwards it downstream, and routes each response back to its originating manager after the fixed TCB response delay DLY.
- Sits between the core and memory, on the same busses the TCB monitor observes.

Parameters:
- DLY, 1, TCB response delay in cycles (0..4); a response is valid DLY cycles after the transfer (vld & rdy).
- AW, 32, address width.
- DW, 32, data width.
- BW, DW/8, byte-enable width.
- RR, 1'b1, arbitration policy: 1 = round-robin, 0 = fixed priority with LSU over IFU.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- ifu_vld/ifu_wen/ifu_adr/ifu_ben/ifu_wdt  input  1/1/AW/BW/DW  IFU manager request
- ifu_rdy  output  1  IFU request accepted
- ifu_rdt/ifu_err  output  DW/1  IFU response
- lsu_vld/lsu_wen/lsu_adr/lsu_ben/lsu_wdt  input  1/1/AW/BW/DW  LSU manager request
- lsu_rdy  output  1  LSU request accepted
- lsu_rdt/lsu_err  output  DW/1  LSU response
- sub_vld/sub_wen/sub_adr/sub_ben/sub_wdt  output  1/1/AW/BW/DW  subordinate request
- sub_rdy  input  1  subordinate ready
- sub_rdt/sub_err  input  DW/1  subordinate response
- sub_gnt  output  1  current grant (0 = IFU, 1 = LSU), for debug and monitors

Behaviour:
- Transfer rule: a transfer occurs on a port when vld & rdy are both high in the same cycle.
- Managers: once a manager raises vld, it holds vld and the request fields stable until rdy.
- Arbitration is combinational on the current vld inputs plus the registered state:
  - lock (1b): set when sub_vld & !sub_rdy; cleared on the transfer.
  - lgnt (1b): owner of the locked request.
  - last (1b): last-served manager, used for round-robin.
- Grant selection:
  - If lock is set, gnt = lgnt; switching away from an unaccepted request is forbidden.
  - Else if only one manager has vld, that manager is granted.
  - Else, if both have vld: RR=1 grants the manager other than last; RR=0 grants the LSU.
  - Else (neither has vld), gnt holds last.
- Request path:
  - sub_* request fields are muxed from the granted manager.
  - sub_vld = vld of the granted manager.
  - Granted manager's rdy = sub_rdy; the other manager's rdy = 0.
- last updates to gnt on every subordinate transfer only.
- Response routing:
  - A DLY-stage shift register carries {v, id} per stage; stage 0 is loaded with {sub transfer, gnt}.
  - At the output stage, if v and id = 0, drive ifu_rdt/ifu_err from sub_rdt/sub_err; if id = 1, drive the lsu_* response.
  - The non-selected manager's rdt = 0 and err = 0.
- DLY = 0: no shift register; the response is routed by the same-cycle gnt, combinationally.
- Pipelining: back-to-back transfers from alternating managers each cycle are supported; no bubbles are inserted.
- Reset values: lock=0, lgnt=0, last=1 (so the IFU wins the first tie under RR), all shift stages v=0.
  - Outputs follow from these: sub_vld = 0 when no inputs are valid; ifu_rdt/lsu_rdt/err = 0.
- Reset mid-operation: any in-flight responses are discarded, with no spurious routing after release.
- Simultaneous events:
  - A new vld from the other manager while lock is set waits.
  - A lock clear and a new arbitration in the same cycle: the next cycle arbitrates normally using the updated last.
- Error: sub_err is forwarded unchanged with its response and has no effect on arbitration.

Test Plan:
- Reset: assert rst mid-stream with 2 transfers in flight (DLY=2) -> all outputs 0 during reset; no response appears on either manager after release.
- Solo traffic: IFU reads 0x0000_0000..0x0000_000C, sub_rdy=1, DLY=1 -> four back-to-back transfers; ifu_rdt equals sub_rdt one cycle later; lsu_rdy=0 throughout.
- Contention with RR=1: both vld continuously, sub_rdy=1 -> grants alternate IFU, LSU, IFU, LSU…; each response returns to the correct manager (IFU rdt 0xAAAA_0000+n, LSU 0x5555_0000+n).
- Contention with RR=0: both vld for 3 cycles -> LSU is served 3 times and IFU stalls (ifu_rdy=0); IFU is granted in the first cycle LSU drops vld.
- Lock under backpressure: IFU vld at adr 0x100, sub_rdy=0 for 3 cycles, LSU vld arrives in cycle 1 -> sub_adr stays 0x100 and sub_gnt=0 until sub_rdy=1; the LSU transfer follows in the next cycle.
- Store/error passthrough: LSU store adr 0x200, wdt 0xDEAD_BEEF, ben 4'b0011, sub_err=1 -> sub_* fields match exactly; lsu_err=1 DLY cycles later; ifu_err stays 0.
